// File: rtl/gift_dual_port_mem.sv
// Simple-dual-port store for GIFT round keys and state snapshots: port A writes,
// port B reads, with a hardware zeroing sweep, range checks and 1/2-cycle reads.
module gift_dual_port_mem #(
   parameter int unsigned DATA_W   = 136,
   parameter int unsigned DEPTH    = 40,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned WR_FIRST = 0
) (
   input  logic              inClk,
   input  logic              inRstN,
   input  logic              inClear,
   output logic              outReady,
   input  logic              inAWr,
   input  logic [ADDR_W-1:0] inAAddr,
   input  logic [DATA_W-1:0] inAData,
   output logic              outAErr,
   input  logic              inBRd,
   input  logic [ADDR_W-1:0] inBAddr,
   output logic [DATA_W-1:0] outBData,
   output logic              outBValid,
   output logic              outBErr
);

   localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   localparam logic [0:0] ST_SWEEP = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [0:0]        r_state;
   logic [0:0]        w_state_nxt;
   logic [IDX_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  w_cnt_nxt;
   logic              r_ready;
   logic              r_aerr;
   logic              r_v1;
   logic              r_e1;
   logic [DATA_W-1:0] r_d1;

   logic              w_a_in;
   logic              w_b_in;
   logic              w_wr_ok;
   logic              w_rd_go;
   logic              w_mem_we;
   logic [IDX_W-1:0]  w_a_idx;
   logic [IDX_W-1:0]  w_b_idx;
   logic [IDX_W-1:0]  w_mem_waddr;
   logic [DATA_W-1:0] w_mem_wdata;
   logic [DATA_W-1:0] w_rd_data;

   // Full-width range checks so out-of-range addresses never alias onto real words
   assign w_a_in  = ({1'b0, inAAddr} < DEPTH_X);
   assign w_b_in  = ({1'b0, inBAddr} < DEPTH_X);
   assign w_a_idx = IDX_W'(inAAddr);
   assign w_b_idx = IDX_W'(inBAddr);

   // A clear pulse revokes readiness from its own edge, so it also drops that write
   assign w_wr_ok = inRstN & r_ready & inAWr & w_a_in & ~inClear;
   assign w_rd_go = r_ready & inBRd;

   always_ff @(posedge inClk) begin
      if (!inRstN) begin
         r_state <= ST_SWEEP;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_SWEEP: begin
            if (inClear) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == LAST_IDX) begin
               w_state_nxt = ST_READY;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + IDX_W'(1);
            end
         end
         ST_READY: begin
            if (inClear) begin
               w_state_nxt = ST_SWEEP;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_SWEEP;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // The sweep owns the write port while it runs
   always_comb begin
      w_mem_we    = w_wr_ok;
      w_mem_waddr = w_a_idx;
      w_mem_wdata = inAData;
      if (r_state == ST_SWEEP) begin
         w_mem_we    = 1'b1;
         w_mem_waddr = r_cnt;
         w_mem_wdata = '0;
      end
   end

   always_ff @(posedge inClk) begin
      if (w_mem_we) begin
         r_mem[w_mem_waddr] <= w_mem_wdata;
      end
   end

   always_comb begin
      w_rd_data = r_mem[w_b_idx];
      if (!w_b_in) begin
         w_rd_data = '0;
      end else if ((WR_FIRST != 0) && w_wr_ok && (inAAddr == inBAddr)) begin
         w_rd_data = inAData;
      end
   end

   always_ff @(posedge inClk) begin
      if (!inRstN) begin
         r_ready <= 1'b0;
         r_aerr  <= 1'b0;
         r_v1    <= 1'b0;
         r_e1    <= 1'b0;
         r_d1    <= '0;
      end else begin
         r_ready <= (w_state_nxt == ST_READY);
         r_aerr  <= inAWr & ~w_wr_ok;
         r_v1    <= w_rd_go;
         r_e1    <= w_rd_go & ~w_b_in;
         if (w_rd_go) begin
            r_d1 <= w_rd_data;
         end
      end
   end

   assign outReady = r_ready;
   assign outAErr  = r_aerr;

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic              r_v2;
         logic              r_e2;
         logic [DATA_W-1:0] r_d2;

         always_ff @(posedge inClk) begin
            if (!inRstN) begin
               r_v2 <= 1'b0;
               r_e2 <= 1'b0;
               r_d2 <= '0;
            end else begin
               r_v2 <= r_v1;
               r_e2 <= r_e1;
               if (r_v1) begin
                  r_d2 <= r_d1;
               end
            end
         end

         assign outBValid = r_v2;
         assign outBErr   = r_e2;
         assign outBData  = r_d2;
      end else begin : g_lat1
         assign outBValid = r_v1;
         assign outBErr   = r_e1;
         assign outBData  = r_d1;
      end
   endgenerate

endmodule

// File: tb/tb_gift_dual_port_mem.sv
// Scoreboard bench: two instances (RD_LAT=1/WR_FIRST=0 and RD_LAT=2/WR_FIRST=1)
// share stimulus; a behavioural model predicts ready, write errors and read results.
module tb_gift_dual_port_mem;

   localparam int unsigned DW = 136;
   localparam int unsigned AW = 8;

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
      int            due;
   } rd_t;

   logic          clk = 1'b0;
   logic          inRstN;
   logic          inClear;
   logic          inAWr;
   logic [AW-1:0] inAAddr;
   logic [DW-1:0] inAData;
   logic          inBRd;
   logic [AW-1:0] inBAddr;

   logic          ready  [2];
   logic          aerr   [2];
   logic [DW-1:0] bdata  [2];
   logic          bvalid [2];
   logic          berr   [2];

   always #5 clk = ~clk;

   gift_dual_port_mem #(.DATA_W(DW), .DEPTH(40), .ADDR_W(AW), .RD_LAT(1), .WR_FIRST(0)) u0 (
      .inClk(clk), .inRstN(inRstN), .inClear(inClear), .outReady(ready[0]),
      .inAWr(inAWr), .inAAddr(inAAddr), .inAData(inAData), .outAErr(aerr[0]),
      .inBRd(inBRd), .inBAddr(inBAddr), .outBData(bdata[0]),
      .outBValid(bvalid[0]), .outBErr(berr[0])
   );

   gift_dual_port_mem #(.DATA_W(DW), .DEPTH(40), .ADDR_W(AW), .RD_LAT(2), .WR_FIRST(1)) u1 (
      .inClk(clk), .inRstN(inRstN), .inClear(inClear), .outReady(ready[1]),
      .inAWr(inAWr), .inAAddr(inAAddr), .inAData(inAData), .outAErr(aerr[1]),
      .inBRd(inBRd), .inBAddr(inBAddr), .outBData(bdata[1]),
      .outBValid(bvalid[1]), .outBErr(berr[1])
   );

   int            n_cmp = 0;
   int            n_bad = 0;
   int            n_step = 0;
   rd_t           q0[$];
   rd_t           q1[$];
   logic [DW-1:0] m_mem [0:39];
   logic          m_ready;
   logic [5:0]    m_cnt;
   logic          m_aerr;
   logic [DW-1:0] last_d [2];
   logic [DW-1:0] pat_a5;
   logic [DW-1:0] pat_x;
   logic [DW-1:0] pat_y;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @step %0d: got %h expected %h", tag, n_step, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd();
      return DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
   endfunction

   task automatic check_port(input int p);
      rd_t  e;
      logic hv;
      if (p == 0) hv = (q0.size() > 0) && (q0[0].due == n_step);
      else        hv = (q1.size() > 0) && (q1[0].due == n_step);
      check($sformatf("u%0d.valid", p), DW'(bvalid[p]), DW'(hv));
      if (hv) begin
         if (p == 0) e = q0.pop_front();
         else        e = q1.pop_front();
         check($sformatf("u%0d.data", p), bdata[p], e.data);
         check($sformatf("u%0d.err", p), DW'(berr[p]), DW'(e.err));
         last_d[p] = e.data;
      end else begin
         check($sformatf("u%0d.hold", p), bdata[p], last_d[p]);
         check($sformatf("u%0d.err_idle", p), DW'(berr[p]), '0);
      end
   endtask

   task automatic step(input logic rst, input logic clr, input logic wr, input logic [AW-1:0] aa,
                       input logic [DW-1:0] ad, input logic rd, input logic [AW-1:0] ba);
      rd_t  e0;
      rd_t  e1;
      logic acc;
      inRstN  = rst;
      inClear = clr;
      inAWr   = wr;
      inAAddr = aa;
      inAData = ad;
      inBRd   = rd;
      inBAddr = ba;
      acc = m_ready && wr && (aa < 8'd40) && !clr;
      if (rst && m_ready && rd) begin
         e0.err = (ba >= 8'd40);
         e1.err = e0.err;
         if (ba >= 8'd40) begin
            e0.data = '0;
            e1.data = '0;
         end else begin
            e0.data = m_mem[ba[5:0]];
            e1.data = (acc && (aa == ba)) ? ad : m_mem[ba[5:0]];
         end
         e0.due = n_step + 1;
         e1.due = n_step + 2;
         q0.push_back(e0);
         q1.push_back(e1);
      end
      if (!rst) begin
         m_ready   = 1'b0;
         m_cnt     = '0;
         m_aerr    = 1'b0;
         q0.delete();
         q1.delete();
         last_d[0] = '0;
         last_d[1] = '0;
      end else begin
         m_aerr = wr && !acc;
         if (m_ready) begin
            if (acc) m_mem[aa[5:0]] = ad;
            if (clr) begin
               m_ready = 1'b0;
               m_cnt   = '0;
            end
         end else begin
            m_mem[m_cnt] = '0;
            if (clr) begin
               m_cnt = '0;
            end else if (m_cnt == 6'd39) begin
               m_ready = 1'b1;
               m_cnt   = '0;
            end else begin
               m_cnt = m_cnt + 6'd1;
            end
         end
      end
      @(posedge clk);
      #1;
      n_step++;
      check_port(0);
      check_port(1);
      for (int p = 0; p < 2; p++) begin
         check($sformatf("u%0d.ready", p), DW'(ready[p]), DW'(m_ready));
         check($sformatf("u%0d.aerr", p), DW'(aerr[p]), DW'(m_aerr));
      end
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, 8'd0, '0, 1'b0, 8'd0);
   endtask

   task automatic do_rst();
      step(1'b0, 1'b0, 1'b0, 8'd0, '0, 1'b0, 8'd0);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      step(1'b1, 1'b0, 1'b1, a, d, 1'b0, 8'd0);
   endtask

   task automatic rd(input logic [AW-1:0] a);
      step(1'b1, 1'b0, 1'b0, 8'd0, '0, 1'b1, a);
   endtask

   task automatic wrrd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [AW-1:0] b);
      step(1'b1, 1'b0, 1'b1, a, d, 1'b1, b);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 100 && !m_ready; i++) idle();
   endtask

   task automatic read_all();
      for (int i = 0; i < 40; i++) rd(8'(i));
      repeat (3) idle();
   endtask

   initial begin
      pat_a5 = {17{8'hA5}};
      pat_x  = rnd();
      pat_y  = rnd();
      for (int i = 0; i < 40; i++) m_mem[i] = rnd();
      m_ready   = 1'b0;
      m_cnt     = '0;
      m_aerr    = 1'b0;
      last_d[0] = '0;
      last_d[1] = '0;

      // Reset, 40-cycle sweep, everything reads zero
      do_rst();
      do_rst();
      wait_ready();
      read_all();

      // Single write then read at both latencies
      wr(8'd5, pat_a5);
      rd(8'd5);
      repeat (3) idle();

      // Fill with random words, stream back 40 consecutive reads
      for (int i = 0; i < 40; i++) wr(8'(i), rnd());
      read_all();

      // Same-cycle collision on address 7, then a plain follow-up read
      wr(8'd7, pat_y);
      wrrd(8'd7, pat_x, 8'd7);
      rd(8'd7);
      repeat (3) idle();

      // Out-of-range writes and reads; 69 would alias address 5 if truncated
      wrrd(8'd40, rnd(), 8'd200);
      wr(8'd69, rnd());
      wr(8'd255, rnd());
      rd(8'd5);
      rd(8'd40);
      rd(8'd39);
      repeat (3) idle();

      // Clear in READY with a write and read, then restart the sweep at counter 10
      step(1'b1, 1'b1, 1'b1, 8'd3, rnd(), 1'b1, 8'd3);
      repeat (10) idle();
      step(1'b1, 1'b1, 1'b1, 8'd2, rnd(), 1'b1, 8'd2);
      wait_ready();
      read_all();

      // Reset while a 2-cycle read is in flight
      wr(8'd5, pat_a5);
      rd(8'd5);
      do_rst();
      idle();
      wait_ready();
      rd(8'd5);
      repeat (3) idle();

      check("q0_drained", DW'(q0.size()), '0);
      check("q1_drained", DW'(q1.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
